// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Brief    : Requester ports A/B plus bus_controller request signals for bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 8,
    parameter int MTYPE_BITS = 3
);
    logic                  a_req;
    logic [MTYPE_BITS-1:0] a_mtype;
    logic [ADDR_BITS-1:0]  a_addr;
    logic [DATA_BITS-1:0]  a_wdata;
    logic [DATA_BITS-1:0]  a_rdata;
    logic                  a_done;
    logic                  a_err;

    logic                  b_req;
    logic [MTYPE_BITS-1:0] b_mtype;
    logic [ADDR_BITS-1:0]  b_addr;
    logic [DATA_BITS-1:0]  b_wdata;
    logic [DATA_BITS-1:0]  b_rdata;
    logic                  b_done;
    logic                  b_err;

    logic                  mreq;
    logic [MTYPE_BITS-1:0] mtype;
    logic [ADDR_BITS-1:0]  maddr;
    logic [DATA_BITS-1:0]  mdata_in;
    logic [DATA_BITS-1:0]  mdata_out;
    logic                  mdone;
    logic                  grant;
    logic                  busy;

    // Arbiter side
    modport master (
        input  a_req, a_mtype, a_addr, a_wdata,
        input  b_req, b_mtype, b_addr, b_wdata,
        input  mdata_out, mdone,
        output a_rdata, a_done, a_err,
        output b_rdata, b_done, b_err,
        output mreq, mtype, maddr, mdata_in, grant, busy
    );

    // Requesters and bus_controller side
    modport slave (
        output a_req, a_mtype, a_addr, a_wdata,
        output b_req, b_mtype, b_addr, b_wdata,
        output mdata_out, mdone,
        input  a_rdata, a_done, a_err,
        input  b_rdata, b_done, b_err,
        input  mreq, mtype, maddr, mdata_in, grant, busy
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin sharing of one bus_controller request port between
//            two requesters, with a stall watchdog on the mdone handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int ADDR_BITS    = 16,
    parameter int DATA_BITS    = 8,
    parameter int MTYPE_BITS   = 3,
    parameter int TIMEOUT_BITS = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Count value on which the (2^TIMEOUT_BITS-1)th busy cycle without mdone ends
    localparam logic [TIMEOUT_BITS-1:0] c_ABORT_AT = TIMEOUT_BITS'((1 << TIMEOUT_BITS) - 2);

    state_t                  r_state;
    logic                    r_last_grant;
    logic [TIMEOUT_BITS-1:0] r_count;

    logic                    w_any_req;
    logic                    w_pick_b;
    logic [MTYPE_BITS-1:0]   w_sel_mtype;
    logic [ADDR_BITS-1:0]    w_sel_addr;
    logic [DATA_BITS-1:0]    w_sel_wdata;

    // On a tie the port that did not win last time takes the bus
    assign w_any_req   = bus.a_req | bus.b_req;
    assign w_pick_b    = bus.b_req & (~bus.a_req | ~r_last_grant);
    assign w_sel_mtype = w_pick_b ? bus.b_mtype : bus.a_mtype;
    assign w_sel_addr  = w_pick_b ? bus.b_addr  : bus.a_addr;
    assign w_sel_wdata = w_pick_b ? bus.b_wdata : bus.a_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_count      <= '0;
            bus.a_rdata  <= '0;
            bus.a_done   <= 1'b0;
            bus.a_err    <= 1'b0;
            bus.b_rdata  <= '0;
            bus.b_done   <= 1'b0;
            bus.b_err    <= 1'b0;
            bus.mreq     <= 1'b0;
            bus.mtype    <= '0;
            bus.maddr    <= '0;
            bus.mdata_in <= '0;
            bus.grant    <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.a_done <= 1'b0;
            bus.a_err  <= 1'b0;
            bus.b_done <= 1'b0;
            bus.b_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        bus.mtype    <= w_sel_mtype;
                        bus.maddr    <= w_sel_addr;
                        bus.mdata_in <= w_sel_wdata;
                        bus.grant    <= w_pick_b;
                        r_last_grant <= w_pick_b;
                        bus.mreq     <= 1'b1;
                        bus.busy     <= 1'b1;
                        r_count      <= '0;
                        r_state      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (bus.mdone) begin
                        if (bus.grant) begin
                            bus.b_rdata <= bus.mdata_out;
                            bus.b_done  <= 1'b1;
                        end else begin
                            bus.a_rdata <= bus.mdata_out;
                            bus.a_done  <= 1'b1;
                        end
                        bus.mreq <= 1'b0;
                        r_state  <= ST_RELEASE;
                    end else if (r_count == c_ABORT_AT) begin
                        // Watchdog abort: report an error with zeroed read data
                        if (bus.grant) begin
                            bus.b_rdata <= '0;
                            bus.b_done  <= 1'b1;
                            bus.b_err   <= 1'b1;
                        end else begin
                            bus.a_rdata <= '0;
                            bus.a_done  <= 1'b1;
                            bus.a_err   <= 1'b1;
                        end
                        bus.mreq <= 1'b0;
                        r_state  <= ST_RELEASE;
                    end else begin
                        r_count <= r_count + TIMEOUT_BITS'(1);
                    end
                end

                ST_RELEASE: begin
                    bus.busy <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    bus.mreq <= 1'b0;
                    bus.busy <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Transaction-level checking of bus_arbiter against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int c_AB   = 16;
    localparam int c_DB   = 8;
    localparam int c_MB   = 3;
    localparam int c_TB   = 4;
    localparam int c_TLIM = (1 << c_TB) - 1;   // busy cycles allowed without mdone
    localparam logic [2:0] c_RDATA = 3'd1;
    localparam logic [2:0] c_WDATA = 3'd2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: who won last, and each port's last returned byte
    bit         m_last;
    logic [7:0] m_rd [2];

    bus_arbiter_if #(.ADDR_BITS(c_AB), .DATA_BITS(c_DB), .MTYPE_BITS(c_MB)) bus ();

    bus_arbiter #(
        .ADDR_BITS   (c_AB),
        .DATA_BITS   (c_DB),
        .MTYPE_BITS  (c_MB),
        .TIMEOUT_BITS(c_TB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mreq"},   32'(bus.mreq),    0);
        chk({tag, "_busy"},   32'(bus.busy),    0);
        chk({tag, "_adone"},  32'(bus.a_done),  0);
        chk({tag, "_bdone"},  32'(bus.b_done),  0);
        chk({tag, "_ardata"}, 32'(bus.a_rdata), 32'(m_rd[0]));
        chk({tag, "_brdata"}, 32'(bus.b_rdata), 32'(m_rd[1]));
    endtask

    task automatic do_reset;
        rst_n         = 1'b0;
        bus.a_req     = 1'b0; bus.b_req   = 1'b0;
        bus.a_mtype   = '0;   bus.b_mtype = '0;
        bus.a_addr    = '0;   bus.b_addr  = '0;
        bus.a_wdata   = '0;   bus.b_wdata = '0;
        bus.mdone     = 1'b0;
        bus.mdata_out = '0;
        step;
        step;
        m_last = 1'b1;
        m_rd[0] = '0;
        m_rd[1] = '0;
        chk_idle("rst");
        chk("rst_grant", 32'(bus.grant),    0);
        chk("rst_maddr", 32'(bus.maddr),    0);
        chk("rst_mtype", 32'(bus.mtype),    0);
        chk("rst_mdin",  32'(bus.mdata_in), 0);
        chk("rst_aerr",  32'(bus.a_err),    0);
        chk("rst_berr",  32'(bus.b_err),    0);
        rst_n = 1'b1;
    endtask

    // One full transaction from the IDLE cycle with requests presented.
    // d: mdone is asserted d cycles after mreq rises (large d -> watchdog).
    task automatic run_txn(input int d, input logic [7:0] rdv, input bit drop, input bit raise_a);
        bit         w;
        bit         to;
        int         len;
        logic [2:0] e_mt;
        logic [15:0] e_ad;
        logic [7:0] e_wd;
        w      = (bus.a_req && bus.b_req) ? ~m_last : bus.b_req;
        m_last = w;
        e_mt   = w ? bus.b_mtype : bus.a_mtype;
        e_ad   = w ? bus.b_addr  : bus.a_addr;
        e_wd   = w ? bus.b_wdata : bus.a_wdata;
        to     = (d + 1 > c_TLIM);
        len    = to ? c_TLIM : d + 1;

        step;
        chk("g_grant", 32'(bus.grant),  32'(w));
        chk("g_busy",  32'(bus.busy),   1);
        chk("g_adone", 32'(bus.a_done), 0);
        chk("g_bdone", 32'(bus.b_done), 0);
        for (int i = 0; i < len; i++) begin
            chk("b_mreq",  32'(bus.mreq),     1);
            chk("b_maddr", 32'(bus.maddr),    32'(e_ad));
            chk("b_mtype", 32'(bus.mtype),    32'(e_mt));
            chk("b_mdin",  32'(bus.mdata_in), 32'(e_wd));
            bus.mdone     = (i == d);
            bus.mdata_out = (i == d) ? rdv : 8'($urandom);
            bus.a_mtype = 3'($urandom);  bus.b_mtype = 3'($urandom);
            bus.a_addr  = 16'($urandom); bus.b_addr  = 16'($urandom);
            bus.a_wdata = 8'($urandom);  bus.b_wdata = 8'($urandom);
            if (raise_a && i == 0) bus.a_req = 1'b1;
            step;
        end
        bus.mdone = 1'b0;

        m_rd[w] = to ? 8'h00 : rdv;
        chk("d_mreq",   32'(bus.mreq),    0);
        chk("d_busy",   32'(bus.busy),    1);
        chk("d_grant",  32'(bus.grant),   32'(w));
        chk("d_adone",  32'(bus.a_done),  32'(!w));
        chk("d_bdone",  32'(bus.b_done),  32'(w));
        chk("d_aerr",   32'(bus.a_err),   32'(!w && to));
        chk("d_berr",   32'(bus.b_err),   32'(w && to));
        chk("d_ardata", 32'(bus.a_rdata), 32'(m_rd[0]));
        chk("d_brdata", 32'(bus.b_rdata), 32'(m_rd[1]));
        if (drop) begin
            if (w) bus.b_req = 1'b0;
            else   bus.a_req = 1'b0;
        end
        step;
        chk_idle("rel");
    endtask

    initial begin
        do_reset;

        // Single read from A
        bus.a_req = 1'b1; bus.a_mtype = c_RDATA; bus.a_addr = 16'h0012; bus.a_wdata = 8'h11;
        run_txn(3, 8'h5A, 1'b1, 1'b0);
        chk("t1_ardata", 32'(bus.a_rdata), 32'h5A);

        // Both held continuously: strict alternation starting with A
        do_reset;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_txn(int'($urandom_range(0, 4)), 8'($urandom), 1'b0, 1'b0);
            chk("fair_seq", 32'(bus.grant), 32'(i % 2));
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        step;

        // B write while A arrives mid-transaction
        bus.b_req = 1'b1; bus.b_mtype = c_WDATA; bus.b_addr = 16'h7FFF; bus.b_wdata = 8'hC3;
        run_txn(4, 8'h3C, 1'b1, 1'b1);
        chk("t3_a_pending", 32'(bus.a_req), 1);
        run_txn(2, 8'h96, 1'b1, 1'b0);
        chk("t3_a_last", 32'(bus.grant), 0);

        // Watchdog boundary: mdone on the last allowed cycle, then never
        bus.a_req = 1'b1; bus.a_addr = 16'h1234;
        run_txn(c_TLIM - 1, 8'hE7, 1'b1, 1'b0);
        bus.a_req = 1'b1;
        run_txn(1000, 8'hFF, 1'b1, 1'b0);
        chk("to_ardata", 32'(bus.a_rdata), 0);
        bus.b_req = 1'b1;
        run_txn(1, 8'h42, 1'b1, 1'b0);

        // Reset while BUSY
        bus.a_req = 1'b1;
        step; step; step;
        chk("rb_busy_pre", 32'(bus.busy), 1);
        rst_n = 1'b0;
        step;
        chk("rb_mreq",  32'(bus.mreq),   0);
        chk("rb_busy",  32'(bus.busy),   0);
        chk("rb_adone", 32'(bus.a_done), 0);
        chk("rb_bdone", 32'(bus.b_done), 0);
        rst_n = 1'b1;
        m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        run_txn(2, 8'h77, 1'b1, 1'b0);
        chk("rb_first_a", 32'(bus.grant), 0);
        run_txn(0, 8'h88, 1'b1, 1'b0);

        // Spurious mdone while IDLE
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mdone = 1'b1; bus.mdata_out = 8'($urandom);
            step;
            chk_idle("spur");
        end
        bus.mdone = 1'b0;
        step;

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            bus.a_req   = 1'($urandom);      bus.b_req   = 1'($urandom);
            bus.a_mtype = 3'($urandom);      bus.b_mtype = 3'($urandom);
            bus.a_addr  = 16'($urandom);     bus.b_addr  = 16'($urandom);
            bus.a_wdata = 8'($urandom);      bus.b_wdata = 8'($urandom);
            if (!bus.a_req && !bus.b_req) begin
                bus.mdone = 1'($urandom); bus.mdata_out = 8'($urandom);
                step;
                bus.mdone = 1'b0;
                chk_idle("rnd_idle");
            end else begin
                run_txn(($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 6)),
                        8'($urandom), 1'($urandom), 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
